// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared constants for the WS2812B frame sequencer and bit encoder.
// Holds the state encoding, the GRB word layout, the latch default and the encoder bit timing.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  localparam int BITS_PER_LED     = 24;
  localparam int LATCH_CYCLES_DEF = 6000;

  // GRB word layout, MSB (green bit 7) goes out first
  localparam int GRB_G_MSB = 23;
  localparam int GRB_G_LSB = 16;
  localparam int GRB_R_MSB = 15;
  localparam int GRB_R_LSB = 8;
  localparam int GRB_B_MSB = 7;
  localparam int GRB_B_LSB = 0;

  // encoder high/low times in clk cycles at 100 MHz
  localparam int T0H_CYCLES = 40;
  localparam int T0L_CYCLES = 85;
  localparam int T1H_CYCLES = 80;
  localparam int T1L_CYCLES = 45;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_latch_timer.sv
// ws2812_latch_timer: loadable down-counter that flags the last cycle of the latch gap.
// Ports: clk, reset (sync, active high), load (start a gap), done (high on final count).
module ws2812_latch_timer
  import ws2812_pkg::*;
#(
  parameter int CYCLES = LATCH_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int TW = $clog2(CYCLES + 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // after load the count reads CYCLES, so the value 1
  // marks the CYCLES-th cycle of the gap
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TW'(CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == TW'(1));

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer: fetches GRB words, feeds bits to the encoder, then holds the latch gap.
// Ports: clk, reset, start, pixAddr/pixData (sync-read store), bitValid/bitData/bitDone,
// busy, frameDone. Macro WS2812_AUTO_REFRESH_EN makes frames repeat after each latch gap.
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 4,
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic [addr_w(NUM_LEDS)-1:0] pixAddr,
  input  logic [BITS_PER_LED-1:0]     pixData,
  output logic                        bitValid,
  output logic                        bitData,
  input  logic                        bitDone,
  output logic                        busy,
  output logic                        frameDone
);

  localparam int AW = addr_w(NUM_LEDS);
  localparam int LW = $clog2(NUM_LEDS + 1);

  localparam logic [4:0]    LAST_BIT = 5'(BITS_PER_LED - 1);
  localparam logic [LW-1:0] LAST_LED = LW'(NUM_LEDS - 1);

  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [BITS_PER_LED-1:0] shift_q, shift_d;
  logic [BITS_PER_LED-1:0] hold_q, hold_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]           led_cnt_q, led_cnt_d;
  logic                    fetch_ph_q, fetch_ph_d;
  logic [1:0]              pf_q, pf_d;
  logic                    tmr_load;
  logic                    tmr_done;

  ws2812_latch_timer #(
    .CYCLES(LATCH_CYCLES)
  ) u_latch (
    .clk  (clk),
    .reset(reset),
    .load (tmr_load),
    .done (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    bit_cnt_d  = bit_cnt_q;
    led_cnt_d  = led_cnt_q;
    fetch_ph_d = 1'b0;
    // pf tracks the read latency: address out, then data back
    pf_d       = {pf_q[0], 1'b0};
    tmr_load   = 1'b0;

    if (pf_q[1]) begin
      hold_d = pixData;
    end

    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (start) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end
      end
      (state_q == ST_FETCH): begin
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          shift_d   = pixData;
          bit_cnt_d = '0;
          led_cnt_d = '0;
          state_d   = ST_SEND;
          if (NUM_LEDS > 1) begin
            addr_d = AW'(1);
            pf_d   = 2'b01;
          end
        end
      end
      (state_q == ST_SEND): begin
        if (bitDone) begin
          if (bit_cnt_q != LAST_BIT) begin
            shift_d   = {shift_q[BITS_PER_LED-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end else begin
            bit_cnt_d = '0;
            if (led_cnt_q == LAST_LED) begin
              state_d   = ST_LATCH;
              led_cnt_d = '0;
              shift_d   = '0;
              tmr_load  = 1'b1;
            end else begin
              // prefetched word goes straight in: no bubble
              shift_d   = hold_q;
              led_cnt_d = led_cnt_q + LW'(1);
              if ((32'(led_cnt_q) + 32'd2) < 32'(NUM_LEDS)) begin
                addr_d = AW'(32'(led_cnt_q) + 32'd2);
                pf_d   = 2'b01;
              end
            end
          end
        end
      end
      (state_q == ST_LATCH): begin
        if (tmr_done) begin
          addr_d = '0;
`ifdef WS2812_AUTO_REFRESH_EN
          state_d = ST_FETCH;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      bit_cnt_q  <= '0;
      led_cnt_q  <= '0;
      fetch_ph_q <= 1'b0;
      pf_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      bit_cnt_q  <= bit_cnt_d;
      led_cnt_q  <= led_cnt_d;
      fetch_ph_q <= fetch_ph_d;
      pf_q       <= pf_d;
    end
  end

  assign pixAddr   = addr_q;
  assign bitValid  = (state_q == ST_SEND);
  assign bitData   = bitValid & shift_q[GRB_G_MSB];
  assign frameDone = (state_q == ST_LATCH) & tmr_done;

`ifdef WS2812_AUTO_REFRESH_EN
  assign busy = (state_q != ST_IDLE);
`else
  // busy drops together with the frameDone pulse
  assign busy = (state_q != ST_IDLE) & ~frameDone;
`endif

endmodule
